// File: rtl/console_writer.sv
// console_writer: turns a ready/valid byte stream into one-byte VRAM writes.
// Handles CR, LF, BS and FF, tracks a cursor, wraps to row 0 and blanks
// every row as it is entered. Rows are never scrolled.
module console_writer #(
    parameter int         COLS  = 40,
    parameter int         ROWS  = 30,
    parameter logic [7:0] BLANK = 8'h20
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [11:0] waddr,
    output logic [7:0]  wdata,
    output logic        we,
    output logic [6:0]  cursor_col,
    output logic [4:0]  cursor_row,
    output logic        busy
);

    localparam logic [7:0]  CH_BS = 8'h08;
    localparam logic [7:0]  CH_LF = 8'h0A;
    localparam logic [7:0]  CH_FF = 8'h0C;
    localparam logic [7:0]  CH_CR = 8'h0D;

    localparam logic [11:0] COLS_12     = 12'(COLS);
    localparam logic [11:0] LINE_LAST   = 12'(COLS - 1);
    localparam logic [11:0] SCREEN_LAST = 12'(COLS * ROWS - 1);
    localparam logic [6:0]  COL_LAST    = 7'(COLS - 1);
    localparam logic [4:0]  ROW_LAST    = 5'(ROWS - 1);

    typedef enum logic [1:0] {
        CLR_SCREEN = 2'd0,
        CLR_LINE   = 2'd1,
        IDLE       = 2'd2
    } state_t;

    state_t      state, state_d;
    logic [11:0] clr_cnt, clr_cnt_d;
    logic [11:0] rowbase, rowbase_d;
    logic [6:0]  col_d;
    logic [4:0]  row_d;
    logic [11:0] waddr_d;
    logic [7:0]  wdata_d;
    logic        we_d;

    // Row advance wraps to the top instead of scrolling; rowbase follows
    // the row by repeated addition so no multiplier is needed.
    logic        last_row;
    logic [4:0]  row_adv;
    logic [11:0] rowbase_adv;

    assign last_row    = (cursor_row == ROW_LAST);
    assign row_adv     = last_row ? 5'd0  : cursor_row + 5'd1;
    assign rowbase_adv = last_row ? 12'd0 : rowbase + COLS_12;

    assign busy     = (state != IDLE);
    assign in_ready = (state == IDLE);

    // State and datapath registers; reset lands in CLR_SCREEN so the
    // screen is cleared right after every reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= CLR_SCREEN;
            clr_cnt    <= 12'd0;
            rowbase    <= 12'd0;
            cursor_col <= 7'd0;
            cursor_row <= 5'd0;
            waddr      <= 12'd0;
            wdata      <= 8'd0;
            we         <= 1'b0;
        end else begin
            state      <= state_d;
            clr_cnt    <= clr_cnt_d;
            rowbase    <= rowbase_d;
            cursor_col <= col_d;
            cursor_row <= row_d;
            waddr      <= waddr_d;
            wdata      <= wdata_d;
            we         <= we_d;
        end
    end

    // Next-state, cursor and write-port decode; waddr/wdata hold when idle.
    always_comb begin
        state_d   = state;
        clr_cnt_d = clr_cnt;
        rowbase_d = rowbase;
        col_d     = cursor_col;
        row_d     = cursor_row;
        waddr_d   = waddr;
        wdata_d   = wdata;
        we_d      = 1'b0;

        case (state)
            CLR_SCREEN: begin
                we_d      = 1'b1;
                waddr_d   = clr_cnt;
                wdata_d   = BLANK;
                clr_cnt_d = clr_cnt + 12'd1;
                if (clr_cnt == SCREEN_LAST) begin
                    clr_cnt_d = 12'd0;
                    state_d   = IDLE;
                end
            end

            CLR_LINE: begin
                we_d      = 1'b1;
                waddr_d   = rowbase + clr_cnt;
                wdata_d   = BLANK;
                clr_cnt_d = clr_cnt + 12'd1;
                if (clr_cnt == LINE_LAST) begin
                    clr_cnt_d = 12'd0;
                    state_d   = IDLE;
                end
            end

            IDLE: begin
                if (in_valid && in_ready) begin
                    case (in_data)
                        CH_CR: col_d = 7'd0;
                        CH_LF: begin
                            col_d     = 7'd0;
                            row_d     = row_adv;
                            rowbase_d = rowbase_adv;
                            clr_cnt_d = 12'd0;
                            state_d   = CLR_LINE;
                        end
                        CH_BS: begin
                            if (cursor_col != 7'd0)
                                col_d = cursor_col - 7'd1;
                        end
                        CH_FF: begin
                            col_d     = 7'd0;
                            row_d     = 5'd0;
                            rowbase_d = 12'd0;
                            clr_cnt_d = 12'd0;
                            state_d   = CLR_SCREEN;
                        end
                        default: begin
                            we_d    = 1'b1;
                            waddr_d = rowbase + {5'd0, cursor_col};
                            wdata_d = in_data;
                            if (cursor_col != COL_LAST) begin
                                col_d = cursor_col + 7'd1;
                            end else begin
                                // Wrap: blank the next row right after this write.
                                col_d     = 7'd0;
                                row_d     = row_adv;
                                rowbase_d = rowbase_adv;
                                clr_cnt_d = 12'd0;
                                state_d   = CLR_LINE;
                            end
                        end
                    endcase
                end
            end

            default: state_d = CLR_SCREEN;
        endcase
    end

endmodule

// File: tb/tb_console_writer.sv
// Bench for console_writer: directed scenarios plus random byte traffic,
// checked against a cursor/VRAM-write model built from the console rules.
module tb_console_writer;

    localparam int COLS  = 40;
    localparam int ROWS  = 30;
    localparam int CELLS = COLS * ROWS;
    localparam logic [7:0] BLANK = 8'h20;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic [11:0] waddr;
    logic [7:0]  wdata;
    logic        we;
    logic [6:0]  cursor_col;
    logic [4:0]  cursor_row;
    logic        busy;

    console_writer #(.COLS(COLS), .ROWS(ROWS), .BLANK(BLANK)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .waddr      (waddr),
        .wdata      (wdata),
        .we         (we),
        .cursor_col (cursor_col),
        .cursor_row (cursor_row),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    typedef struct packed {
        logic [31:0] stamp;
        logic [11:0] a;
        logic [7:0]  d;
    } wr_t;

    wr_t         got_q[$];
    logic [19:0] exp_q[$];
    int          m_col;
    int          m_row;

    always @(posedge clk) cyc <= cyc + 1;

    // Record every VRAM write with the number of clock edges seen so far.
    always @(negedge clk) begin
        if (rst_n && we) got_q.push_back({32'(cyc), waddr, wdata});
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    task automatic m_blank_row();
        for (int i = 0; i < COLS; i++)
            exp_q.push_back({12'(m_row * COLS + i), BLANK});
    endtask

    task automatic m_next_row();
        m_row = (m_row == ROWS - 1) ? 0 : m_row + 1;
        m_blank_row();
    endtask

    task automatic m_clear_screen();
        m_col = 0;
        m_row = 0;
        for (int i = 0; i < CELLS; i++) exp_q.push_back({12'(i), BLANK});
    endtask

    task automatic model_byte(input logic [7:0] b);
        case (b)
            8'h0D: m_col = 0;
            8'h0A: begin m_col = 0; m_next_row(); end
            8'h08: if (m_col > 0) m_col--;
            8'h0C: m_clear_screen();
            default: begin
                exp_q.push_back({12'(m_row * COLS + m_col), b});
                if (m_col < COLS - 1) m_col++;
                else begin m_col = 0; m_next_row(); end
            end
        endcase
    endtask

    // ---------------- driver / helpers ----------------
    task automatic send_byte(input logic [7:0] b, output int acc);
        int waited = 0;
        acc = -1;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = b;
        while (!in_ready && waited < 5000) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) begin
            check_eq("send_ready_timeout", in_ready, 1);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        acc = cyc;
        in_valid = 1'b0;
        model_byte(b);
        check_eq("cursor_col", cursor_col, m_col);
        check_eq("cursor_row", cursor_row, m_row);
        check_eq("busy_vs_ready", busy, !in_ready);
    endtask

    task automatic wait_idle();
        int k = 0;
        @(negedge clk);
        while (!in_ready && k < 5000) begin
            @(negedge clk);
            k++;
        end
        check_eq("idle_timeout", in_ready, 1);
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic count_low(output int n);
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 5000) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic drain(input string tag, input bit consec);
        int breaks = 0;
        int prev = -1;
        logic [19:0] e;
        wr_t g;
        while (exp_q.size() > 0) begin
            if (got_q.size() == 0) begin
                check_eq({tag, "_missing"}, 0, exp_q.size());
                exp_q.delete();
                break;
            end
            e = exp_q.pop_front();
            g = got_q.pop_front();
            check_eq({tag, "_addr"}, g.a, e[19:8]);
            check_eq({tag, "_data"}, g.d, e[7:0]);
            if (consec && prev >= 0 && int'(g.stamp) != prev + 1) breaks++;
            prev = int'(g.stamp);
        end
        if (consec) check_eq({tag, "_consec"}, breaks, 0);
        check_eq({tag, "_extra"}, got_q.size(), 0);
        got_q.delete();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int acc_a, acc_b, acc, nlow, rel, k;
        logic [7:0] b;

        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        m_col    = 0;
        m_row    = 0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_we", we, 0);
        check_eq("rst_waddr", waddr, 0);
        check_eq("rst_wdata", wdata, 0);
        check_eq("rst_in_ready", in_ready, 0);
        check_eq("rst_busy", busy, 1);
        check_eq("rst_col", cursor_col, 0);
        check_eq("rst_row", cursor_row, 0);

        // Power-up clear.
        rst_n = 1'b1;
        rel = cyc;
        m_clear_screen();
        wait_idle();
        if (got_q.size() > 0) check_eq("clr_first_edge", got_q[0].stamp, rel + 1);
        else check_eq("clr_first_edge_none", got_q.size(), 1);
        drain("pwrclr", 1'b1);
        check_eq("pwrclr_col", cursor_col, 0);
        check_eq("pwrclr_row", cursor_row, 0);

        // Two printables back to back.
        send_byte(8'h41, acc_a);
        send_byte(8'h42, acc_b);
        wait_idle();
        if (got_q.size() >= 2) begin
            check_eq("a_latency", got_q[0].stamp, acc_a);
            check_eq("ab_b2b", got_q[1].stamp, got_q[0].stamp + 1);
        end else check_eq("ab_count", got_q.size(), 2);
        drain("ab", 1'b1);
        check_eq("ab_col", cursor_col, 2);

        // Fill row 0 and wrap.
        send_byte(8'h0D, acc);
        for (int i = 0; i < COLS; i++) send_byte(8'h30 + 8'(i % 10), acc);
        count_low(nlow);
        check_eq("wrap_ready_low", nlow, COLS);
        wait_idle();
        if (got_q.size() >= COLS + 1)
            check_eq("wrap_consec", got_q[COLS].stamp, got_q[COLS-1].stamp + 1);
        else check_eq("wrap_count", got_q.size(), 2 * COLS);
        drain("wrap", 1'b1);
        check_eq("wrap_col", cursor_col, 0);
        check_eq("wrap_row", cursor_row, 1);

        // Walk down to the last row, then LF wraps to row 0.
        for (int i = 0; i < ROWS - 2; i++) send_byte(8'h0A, acc);
        check_eq("row29", cursor_row, ROWS - 1);
        send_byte(8'h0A, acc);
        count_low(nlow);
        check_eq("lf_ready_low", nlow, COLS);
        send_byte(8'h5A, acc);
        wait_idle();
        drain("lastlf", 1'b0);

        // Cursor editing without writes.
        send_byte(8'h0A, acc);
        send_byte(8'h0A, acc);
        for (int i = 0; i < 5; i++) send_byte(8'h61 + 8'(i), acc);
        wait_idle();
        drain("edit_setup", 1'b0);
        check_eq("at_5_2", {25'd0, cursor_col}, 5);
        send_byte(8'h08, acc);
        wait_idle();
        drain("bs", 1'b0);
        send_byte(8'h0D, acc);
        wait_idle();
        drain("cr", 1'b0);
        send_byte(8'h08, acc);
        wait_idle();
        drain("bs0", 1'b0);

        // Random traffic.
        for (int i = 0; i < 300; i++) begin
            k = int'($urandom_range(0, 99));
            if (k < 6) b = 8'h0A;
            else if (k < 10) b = 8'h0D;
            else if (k < 16) b = 8'h08;
            else begin
                b = 8'($urandom_range(0, 255));
                while (b == 8'h0A || b == 8'h0D || b == 8'h08 || b == 8'h0C)
                    b = 8'($urandom_range(0, 255));
            end
            send_byte(b, acc);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        wait_idle();
        drain("rnd", 1'b0);

        // Form feed, then reset in the middle of the clear.
        send_byte(8'h0C, acc);
        k = 0;
        while (got_q.size() < CELLS / 2 && k < 5000) begin
            @(posedge clk);
            k++;
        end
        check_eq("ff_progress", got_q.size() >= CELLS / 2, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("midrst_we", we, 0);
        check_eq("midrst_waddr", waddr, 0);
        check_eq("midrst_in_ready", in_ready, 0);
        check_eq("midrst_busy", busy, 1);
        check_eq("midrst_col", cursor_col, 0);
        check_eq("midrst_row", cursor_row, 0);
        exp_q.delete();
        got_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        m_clear_screen();
        wait_idle();
        drain("rstclr", 1'b1);
        send_byte(8'h21, acc);
        wait_idle();
        drain("after_rst", 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
